// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: holds one wide beat and emits its kept lanes
// one per cycle in ascending lane order, carrying the packet's last flag on the final word.
module stream_downsize #(
  parameter int T_DATA_WIDTH = 4,
  parameter int T_DATA_RATIO = 2
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] s_data_i,
  input  logic [T_DATA_RATIO-1:0]                  s_keep_i,
  input  logic                                     s_last_i,
  input  logic                                     s_valid_i,
  output logic                                     s_ready_o,
  output logic [T_DATA_WIDTH-1:0]                  m_data_o,
  output logic                                     m_last_o,
  output logic                                     m_valid_o,
  input  logic                                     m_ready_i
);

  logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] data_q, data_d;
  logic [T_DATA_RATIO-1:0]                   rem_q, rem_d;
  logic                                      last_q, last_d;

  logic [T_DATA_RATIO-1:0] rem_low_cleared;
  logic                    rem_one_hot;
  logic [T_DATA_WIDTH-1:0] lane_sel;

  assign rem_low_cleared = rem_q & (rem_q - T_DATA_RATIO'(1));
  assign rem_one_hot     = (rem_q != '0) && (rem_low_cleared == '0);

  // Descending scan so the lowest set bit of rem wins.
  always_comb begin
    lane_sel = '0;
    for (int i = T_DATA_RATIO - 1; i >= 0; i--) begin
      if (rem_q[i]) lane_sel = data_q[i];
    end
  end

  assign m_valid_o = (rem_q != '0);
  assign m_data_o  = m_valid_o ? lane_sel : '0;
  assign m_last_o  = last_q && rem_one_hot;
  assign s_ready_o = !rst && ((rem_q == '0) || (rem_one_hot && m_ready_i));

  // A new beat load overrides the clear of the word leaving in the same cycle.
  always_comb begin
    data_d = data_q;
    rem_d  = rem_q;
    last_d = last_q;
    if (m_valid_o && m_ready_i) begin
      rem_d = rem_low_cleared;
    end
    if (s_valid_i && s_ready_o) begin
      data_d = s_data_i;
      rem_d  = s_keep_i;
      last_d = s_last_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      rem_q  <= '0;
      last_q <= 1'b0;
    end else begin
      data_q <= data_d;
      rem_q  <= rem_d;
      last_q <= last_d;
    end
  end

endmodule

// File: tb/tb_stream_downsize.sv
// Self-checking bench for stream_downsize: directed vector table, a RATIO=4 sparse-keep
// sequence, and a randomized packet stream checked against a queue-based reference model.
module tb_stream_downsize;

  logic clk;
  logic rst;

  logic [1:0][3:0] s_data2;
  logic [1:0]      s_keep2;
  logic            s_last2, s_valid2, s_ready2;
  logic [3:0]      m_data2;
  logic            m_last2, m_valid2, m_ready2;

  logic [3:0][3:0] s_data4;
  logic [3:0]      s_keep4;
  logic            s_last4, s_valid4, s_ready4;
  logic [3:0]      m_data4;
  logic            m_last4, m_valid4, m_ready4;

  int total = 0;
  int bad   = 0;

  stream_downsize #(.T_DATA_WIDTH(4), .T_DATA_RATIO(2)) dut2 (
    .clk(clk), .rst(rst),
    .s_data_i(s_data2), .s_keep_i(s_keep2), .s_last_i(s_last2), .s_valid_i(s_valid2),
    .s_ready_o(s_ready2),
    .m_data_o(m_data2), .m_last_o(m_last2), .m_valid_o(m_valid2), .m_ready_i(m_ready2)
  );

  stream_downsize #(.T_DATA_WIDTH(4), .T_DATA_RATIO(4)) dut4 (
    .clk(clk), .rst(rst),
    .s_data_i(s_data4), .s_keep_i(s_keep4), .s_last_i(s_last4), .s_valid_i(s_valid4),
    .s_ready_o(s_ready4),
    .m_data_o(m_data4), .m_last_o(m_last4), .m_valid_o(m_valid4), .m_ready_i(m_ready4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            rst;
    logic [1:0][3:0] s_data;
    logic [1:0]      s_keep;
    logic            s_last;
    logic            s_valid;
    logic            m_ready;
    logic            exp_s_ready;
    logic            exp_m_valid;
    logic [3:0]      exp_m_data;
    logic            exp_m_last;
  } vec_t;

  typedef struct {
    logic [1:0][3:0] data;
    logic [1:0]      keep;
    logic            last;
  } beat_t;

  typedef struct {
    logic [3:0] data;
    logic       last;
  } word_t;

  localparam int NVEC = 24;
  vec_t  vecs[NVEC];
  beat_t beats[$];
  word_t exp_q[$];

  function automatic vec_t mk(input logic r, input logic [7:0] d, input logic [1:0] k,
                              input logic l, input logic v, input logic mr,
                              input logic esr, input logic emv, input logic [3:0] emd,
                              input logic eml);
    vec_t t;
    t.rst = r; t.s_data = d; t.s_keep = k; t.s_last = l; t.s_valid = v; t.m_ready = mr;
    t.exp_s_ready = esr; t.exp_m_valid = emv; t.exp_m_data = emd; t.exp_m_last = eml;
    return t;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    @(negedge clk);
    rst      = v.rst;
    s_data2  = v.s_data;
    s_keep2  = v.s_keep;
    s_last2  = v.s_last;
    s_valid2 = v.s_valid;
    m_ready2 = v.m_ready;
    #1;
  endtask

  task automatic run_loopback();
    int         cycles;
    int         bi;
    int         hi;
    logic       holding;
    logic       stalled_prev;
    logic [3:0] prev_data;
    logic       prev_last;
    int         pending;
    word_t      w;
    cycles = 0; bi = 0; holding = 1'b0; stalled_prev = 1'b0;
    prev_data = '0; prev_last = 1'b0;
    while ((bi < beats.size() || holding || exp_q.size() > 0) && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      if (!holding && bi < beats.size() && $urandom_range(3) != 0) begin
        s_data2  = beats[bi].data;
        s_keep2  = beats[bi].keep;
        s_last2  = beats[bi].last;
        s_valid2 = 1'b1;
        holding  = 1'b1;
        bi++;
      end else if (!holding) begin
        s_valid2 = 1'b0;
        s_data2  = 8'($urandom);
        s_keep2  = 2'($urandom);
        s_last2  = 1'($urandom);
      end
      m_ready2 = ($urandom_range(9) < 7);
      #1;
      pending = exp_q.size();
      check_output("lb_s_ready", 32'(s_ready2),
                   32'((pending == 0) || (pending == 1 && m_ready2)));
      check_output("lb_m_valid", 32'(m_valid2), 32'(pending > 0));
      if (stalled_prev) begin
        check_output("lb_stall_data", 32'(m_data2), 32'(prev_data));
        check_output("lb_stall_last", 32'(m_last2), 32'(prev_last));
      end
      if (m_valid2 && m_ready2 && exp_q.size() > 0) begin
        w = exp_q.pop_front();
        check_output("lb_data", 32'(m_data2), 32'(w.data));
        check_output("lb_last", 32'(m_last2), 32'(w.last));
      end
      stalled_prev = m_valid2 && !m_ready2;
      prev_data    = m_data2;
      prev_last    = m_last2;
      if (s_valid2 && s_ready2) begin
        hi = -1;
        for (int i = 0; i < 2; i++) if (s_keep2[i]) hi = i;
        for (int i = 0; i < 2; i++) begin
          if (s_keep2[i]) begin
            w.data = s_data2[i];
            w.last = s_last2 && (i == hi);
            exp_q.push_back(w);
          end
        end
        holding = 1'b0;
      end
    end
    check_output("lb_timeout", 32'(cycles < 20000), 32'd1);
    @(negedge clk);
    s_valid2 = 1'b0;
  endtask

  initial begin
    int nbeats;
    rst = 1'b1;
    s_data2 = '0; s_keep2 = '0; s_last2 = 1'b0; s_valid2 = 1'b0; m_ready2 = 1'b1;
    s_data4 = '0; s_keep4 = '0; s_last4 = 1'b0; s_valid4 = 1'b0; m_ready4 = 1'b1;

    // Reset held for two cycles with the input offering a beat.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      rst = 1'b1; s_valid2 = 1'b1; s_keep2 = 2'b11; s_data2 = 8'h5A;
      #1;
      check_output("rst_s_ready", 32'(s_ready2), 32'd0);
      check_output("rst_m_valid", 32'(m_valid2), 32'd0);
      check_output("rst_m_last",  32'(m_last2),  32'd0);
      check_output("rst_m_data",  32'(m_data2),  32'd0);
    end
    @(negedge clk);
    rst = 1'b0; s_valid2 = 1'b0;
    #1;
    check_output("post_rst_s_ready", 32'(s_ready2), 32'd1);
    check_output("post_rst_m_valid", 32'(m_valid2), 32'd0);

    //           rst data   keep  lst vld mr  sr  mv  md    ml
    vecs[0]  = mk(0, 8'h21, 2'b11, 0, 1, 1,  1, 0, 4'h0, 0);
    vecs[1]  = mk(0, 8'h43, 2'b11, 1, 1, 1,  0, 1, 4'h1, 0);
    vecs[2]  = mk(0, 8'h43, 2'b11, 1, 1, 1,  1, 1, 4'h2, 0);
    vecs[3]  = mk(0, 8'h00, 2'b00, 0, 0, 1,  0, 1, 4'h3, 0);
    vecs[4]  = mk(0, 8'h00, 2'b00, 0, 0, 1,  1, 1, 4'h4, 1);
    vecs[5]  = mk(0, 8'h00, 2'b00, 0, 0, 1,  1, 0, 4'h0, 0);
    vecs[6]  = mk(0, 8'h65, 2'b01, 1, 1, 1,  1, 0, 4'h0, 0);
    vecs[7]  = mk(0, 8'hFF, 2'b00, 0, 1, 1,  1, 1, 4'h5, 1);
    vecs[8]  = mk(0, 8'h87, 2'b10, 1, 1, 1,  1, 0, 4'h0, 0);
    vecs[9]  = mk(0, 8'h00, 2'b00, 0, 0, 1,  1, 1, 4'h8, 1);
    vecs[10] = mk(0, 8'h00, 2'b00, 0, 0, 1,  1, 0, 4'h0, 0);
    vecs[11] = mk(0, 8'hBA, 2'b11, 0, 1, 1,  1, 0, 4'h0, 0);
    vecs[12] = mk(0, 8'hDC, 2'b11, 1, 1, 0,  0, 1, 4'hA, 0);
    vecs[13] = mk(0, 8'hDC, 2'b11, 1, 1, 0,  0, 1, 4'hA, 0);
    vecs[14] = mk(0, 8'hDC, 2'b11, 1, 1, 1,  0, 1, 4'hA, 0);
    vecs[15] = mk(0, 8'hDC, 2'b11, 1, 1, 0,  0, 1, 4'hB, 0);
    vecs[16] = mk(0, 8'hDC, 2'b11, 1, 1, 1,  1, 1, 4'hB, 0);
    vecs[17] = mk(0, 8'h00, 2'b00, 0, 0, 1,  0, 1, 4'hC, 0);
    vecs[18] = mk(0, 8'h00, 2'b00, 0, 0, 0,  0, 1, 4'hD, 1);
    vecs[19] = mk(0, 8'h00, 2'b00, 0, 0, 1,  1, 1, 4'hD, 1);
    vecs[20] = mk(0, 8'h00, 2'b00, 0, 0, 1,  1, 0, 4'h0, 0);
    vecs[21] = mk(0, 8'h21, 2'b11, 1, 1, 1,  1, 0, 4'h0, 0);
    vecs[22] = mk(1, 8'h00, 2'b00, 0, 0, 1,  0, 1, 4'h1, 0);
    vecs[23] = mk(0, 8'h00, 2'b00, 0, 0, 1,  1, 0, 4'h0, 0);

    for (int i = 0; i < NVEC; i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d_s_ready", i), 32'(s_ready2), 32'(vecs[i].exp_s_ready));
      check_output($sformatf("vec%0d_m_valid", i), 32'(m_valid2), 32'(vecs[i].exp_m_valid));
      check_output($sformatf("vec%0d_m_data", i),  32'(m_data2),  32'(vecs[i].exp_m_data));
      check_output($sformatf("vec%0d_m_last", i),  32'(m_last2),  32'(vecs[i].exp_m_last));
    end

    // RATIO=4 sparse keep: lanes 1 and 3 only.
    @(negedge clk);
    s_data4 = 16'h4321; s_keep4 = 4'b1010; s_last4 = 1'b1; s_valid4 = 1'b1; m_ready4 = 1'b1;
    #1;
    check_output("r4_s_ready", 32'(s_ready4), 32'd1);
    @(negedge clk);
    s_valid4 = 1'b0;
    #1;
    check_output("r4_w0_valid", 32'(m_valid4), 32'd1);
    check_output("r4_w0_data",  32'(m_data4),  32'h2);
    check_output("r4_w0_last",  32'(m_last4),  32'd0);
    @(negedge clk);
    #1;
    check_output("r4_w1_valid", 32'(m_valid4), 32'd1);
    check_output("r4_w1_data",  32'(m_data4),  32'h4);
    check_output("r4_w1_last",  32'(m_last4),  32'd1);
    @(negedge clk);
    #1;
    check_output("r4_done_valid", 32'(m_valid4), 32'd0);

    // Random packets, sparse and empty non-last beats included, last beat always non-empty.
    for (int p = 0; p < 60; p++) begin
      nbeats = $urandom_range(5, 1);
      for (int b = 0; b < nbeats; b++) begin
        beat_t bt;
        bt.data = 8'($urandom);
        bt.last = (b == nbeats - 1);
        bt.keep = bt.last ? 2'($urandom_range(3, 1)) : 2'($urandom_range(3, 0));
        beats.push_back(bt);
      end
    end
    run_loopback();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
